sync_fork_n: RTL and testbench
==============================

// Module: sync_fork_n
// PURPOSE
// - Clocked N-way eager fork: one valid/ready input stream broadcast to NUM_OUT valid/ready outputs.
// - Parametrised successor of the two-way request fork.
// - Each branch completes independently; the input is acknowledged only when every enabled branch
//   has accepted the item.
// - Sits between a pipeline stage and parallel consumers (e.g. decoder + scoreboard); per-item branch mask.
// PARAMETERS
// - NUM_OUT  2   number of output branches, >=2
// - DATA_W   32  payload width; 0 not allowed
// PORTS
// - clk_i       in   1               clock; all state on rising edge
// - rst_ni      in   1               asynchronous, active-low reset
// - valid_i     in   1               input item valid
// - ready_o     out  1               input item accepted this cycle (when valid_i=1)
// - data_i      in   DATA_W          input payload
// - mask_i      in   NUM_OUT         branch enable per item; bit k=0 -> branch k skipped
// - valid_o     out  NUM_OUT         per-branch valid
// - ready_i     in   NUM_OUT         per-branch ready
// - data_o      out  NUM_OUT*DATA_W  per-branch payload; slice k = [k*DATA_W +: DATA_W]
// BEHAVIOUR
// - Clock/reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
// - State:
//   - done_q[NUM_OUT]: branch already handshaken for the current item.
//   - init_q: 0 in reset, set to 1 on the first clk_i edge after rst_ni deasserts.
// - Reset (rst_ni=0) and the cycle while init_q=0:
//   - done_q=0; valid_o=0; ready_o=0; data_o=0 (default build).
// - Branch signals (init_q=1):
//   - valid_o[k] = valid_i & mask_i[k] & ~done_q[k]
//   - data_o[k] = data_i
//   - cmp[k] = ~mask_i[k] | done_q[k] | ready_i[k]
// - Input handshake: ready_o = &cmp. Latency 0; combinational ready_i->ready_o path allowed.
// - done_q update per clk_i edge:
//   - valid_i&ready_o: done_q <= 0 (item retired; next item starts clean).
//   - Otherwise, for each k: valid_o[k]&ready_i[k] sets done_q[k]. No branch is ever presented the same item twice.
// - Boundary cases:
//   - mask_i=0 with valid_i=1: ready_o=1, item dropped, no valid_o raised.
//   - All branches ready in the same cycle: item retires in 1 cycle; done_q stays 0.
//   - Branch k ready before others: valid_o[k] drops the next cycle until the item retires.
//   - valid_i=0: valid_o=0; done_q holds (must be 0 by protocol).
// - Protocol (producer): valid_i, data_i, mask_i stable from assertion until ready_o.
//   - Violation flagged by SVA; behaviour undefined.
// - Reset mid-item: done_q cleared asynchronously; the item is re-offered to all enabled branches after reset.
// CONFIGURATION
// - Macro: SYNC_FORK_OUT_REG_EN.
// - Undefined (default): behaviour as above; zero latency; 1 item/cycle max throughput.
// - Defined: adds a one-entry input buffer (buf_vld_q, buf_data_q, buf_mask_q) to break the ready_i->ready_o path.
//   - ready_o = init_q & ~buf_vld_q (registered only).
//   - An accepted item is loaded into the buffer; fork logic above runs on the buffer.
//   - Latency 1 cycle; max throughput 1 item / 2 cycles.
//   - Reset clears buf_vld_q, buf_data_q, buf_mask_q; data_o=0 in reset.
//   - A mask=0 item is still accepted, then retired one cycle later with no valid_o.
// TESTING
// - NUM_OUT=2: valid_i=1, data=0xA5, mask=2'b11, ready_i=2'b11 -> valid_o=2'b11, ready_o=1 same cycle; done_q stays 0.
// - ready_i=01 cyc0, 10 cyc1 -> cyc0: valid_o=11, ready_o=0; cyc1: valid_o=10, ready_o=1; branch0 sees 1 handshake.
// - NUM_OUT=4, mask=4'b0101, ready_i=4'b1111 -> valid_o=4'b0101, ready_o=1.
//   - mask=0 -> ready_o=1, valid_o=0.
// - Assert rst_ni=0 after branch0 done, release -> cycle 0 all outputs 0; then item re-offered with valid_o=11.
// - SYNC_FORK_OUT_REG_EN: 10 back-to-back items, ready_i=all 1 -> first valid_o 1 cycle after accept; 10 items in 20 cycles.
// - Random ready_i/mask, 10k items -> scoreboard: every enabled branch receives each item exactly once, in order.

Source files
------------

// File: rtl/sync_fork_n.sv
// Purpose: N-way eager fork; one valid/ready stream is broadcast to NUM_OUT branches, each completing independently.
// Latency: 0 cycles by default; 1 cycle with SYNC_FORK_OUT_REG_EN (one-entry input buffer, 1 item / 2 cycles).
// Backpressure: the input is held off until every enabled branch has accepted the current item.
module sync_fork_n #(
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_W-1:0]         data_i,
    input  logic [NUM_OUT-1:0]        mask_i,
    output logic [NUM_OUT-1:0]        valid_o,
    input  logic [NUM_OUT-1:0]        ready_i,
    output logic [NUM_OUT*DATA_W-1:0] data_o
);

    logic               init_q;
    logic [NUM_OUT-1:0] done_q;

    // Item currently being forked: the raw input, or the buffered copy.
    logic               src_vld;
    logic [DATA_W-1:0]  src_dat;
    logic [NUM_OUT-1:0] src_msk;

    logic [NUM_OUT-1:0] cmp;
    logic               fork_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    assign cmp       = ~src_msk | done_q | ready_i;
    assign fork_done = init_q & src_vld & (&cmp);
    assign valid_o   = (init_q & src_vld) ? (src_msk & ~done_q) : '0;
    assign data_o    = init_q ? {NUM_OUT{src_dat}} : '0;

`ifdef SYNC_FORK_OUT_REG_EN
    logic               buf_vld_q;
    logic [DATA_W-1:0]  buf_data_q;
    logic [NUM_OUT-1:0] buf_mask_q;

    // Accepting only into an empty buffer keeps ready_o free of any ready_i path.
    assign ready_o = init_q & ~buf_vld_q;
    assign src_vld = buf_vld_q;
    assign src_dat = buf_data_q;
    assign src_msk = buf_mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_vld_q  <= 1'b0;
            buf_data_q <= '0;
            buf_mask_q <= '0;
        end else if (valid_i && ready_o) begin
            buf_vld_q  <= 1'b1;
            buf_data_q <= data_i;
            buf_mask_q <= mask_i;
        end else if (fork_done) begin
            buf_vld_q  <= 1'b0;
        end
    end
`else
    assign ready_o = init_q & (&cmp);
    assign src_vld = valid_i;
    assign src_dat = data_i;
    assign src_msk = mask_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else if (fork_done) begin
            done_q <= '0;
        end else begin
            done_q <= done_q | (valid_o & ready_i);
        end
    end

    // Producer must hold the item steady until it is accepted.
    property p_input_stable;
        @(posedge clk_i) disable iff (!rst_ni)
            (init_q && valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(mask_i));
    endproperty
    a_input_stable: assert property (p_input_stable);

endmodule

// File: tb/tb_sync_fork_n.sv
// Bench for sync_fork_n: directed zero-latency cases on a 2-way and 4-way instance,
// back-to-back throughput, and a randomised scoreboard run checking exactly-once in-order delivery.
module tb_sync_fork_n;

`ifdef SYNC_FORK_OUT_REG_EN
    localparam int REG = 1;
`else
    localparam int REG = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v2 = 1'b0, r2o;
    logic [7:0]  d2 = '0;
    logic [1:0]  m2 = '0, vo2, ri2 = '0;
    logic [15:0] do2;

    logic        v4 = 1'b0, r4o;
    logic [15:0] d4 = '0;
    logic [3:0]  m4 = '0, vo4, ri4 = '0;
    logic [63:0] do4;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] dat;
        logic [3:0]  msk;
    } item_t;
    item_t sb[$];

    always #5 clk = ~clk;

    sync_fork_n #(.NUM_OUT(2), .DATA_W(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(r2o), .data_i(d2),
        .mask_i(m2), .valid_o(vo2), .ready_i(ri2), .data_o(do2)
    );

    sync_fork_n #(.NUM_OUT(4), .DATA_W(16)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .ready_o(r4o), .data_i(d4),
        .mask_i(m4), .valid_o(vo4), .ready_i(ri4), .data_o(do4)
    );

    task automatic do_reset();
        v2 = 1'b0; v4 = 1'b0; ri2 = '0; ri4 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v2 = 1'b1; d2 = 8'h5A; m2 = 2'b11; ri2 = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({vo2, r2o, do2} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_state: valid_o=%b ready_o=%b data_o=%h want all 0", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vo2, r2o, do2} !== 19'd0) begin
            n_bad++;
            $display("FAIL init_cycle: valid_o=%b ready_o=%b data_o=%h want all 0", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 v2 = 1'b0;
        do_reset();
    endtask

    task automatic test_all_ready();
        v2 = 1'b1; d2 = 8'hA5; m2 = 2'b11; ri2 = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (vo2 !== 2'b11 || r2o !== 1'b1 || do2 !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL all_ready: valid_o=%b ready_o=%b data_o=%h want 11 1 a5a5", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 d2 = 8'h11; ri2 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (vo2 !== 2'b11 || r2o !== 1'b0) begin
            n_bad++;
            $display("FAIL done_clean: valid_o=%b ready_o=%b want 11 0", vo2, r2o);
        end
        @(posedge clk);
        #1 ri2 = 2'b11;
        @(posedge clk);
        #1 v2 = 1'b0;
    endtask

    task automatic test_split();
        int hs0;
        hs0 = 0;
        v2 = 1'b1; d2 = 8'h77; m2 = 2'b11; ri2 = 2'b01;
        @(negedge clk);
        hs0 += int'(vo2[0] & ri2[0]);
        n_cmp++;
        if (vo2 !== 2'b11 || r2o !== 1'b0) begin
            n_bad++;
            $display("FAIL split_cyc0: valid_o=%b ready_o=%b want 11 0", vo2, r2o);
        end
        @(posedge clk);
        #1 ri2 = 2'b10;
        @(negedge clk);
        hs0 += int'(vo2[0] & ri2[0]);
        n_cmp++;
        if (vo2 !== 2'b10 || r2o !== 1'b1) begin
            n_bad++;
            $display("FAIL split_cyc1: valid_o=%b ready_o=%b want 10 1", vo2, r2o);
        end
        n_cmp++;
        if (hs0 !== 1) begin
            n_bad++;
            $display("FAIL split_branch0_hs: got %0d handshakes want 1", hs0);
        end
        @(posedge clk);
        #1 v2 = 1'b0; ri2 = 2'b00;
    endtask

    task automatic test_mask4();
        v4 = 1'b1; d4 = 16'hBEEF; m4 = 4'b0101; ri4 = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (vo4 !== 4'b0101 || r4o !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_0101: valid_o=%b ready_o=%b want 0101 1", vo4, r4o);
        end
        @(posedge clk);
        #1 m4 = 4'b0000; ri4 = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (vo4 !== 4'b0000 || r4o !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_zero: valid_o=%b ready_o=%b want 0000 1", vo4, r4o);
        end
        @(posedge clk);
        #1 v4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vo4 !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_valid: valid_o=%b want 0000", vo4);
        end
    endtask

    task automatic test_reset_mid();
        v2 = 1'b1; d2 = 8'h3C; m2 = 2'b11; ri2 = 2'b01;
        @(posedge clk);
        #1 ri2 = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (vo2 !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_branch0_drop: valid_o=%b want 10", vo2);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vo2, r2o, do2} !== 19'd0) begin
            n_bad++;
            $display("FAIL mid_async_reset: valid_o=%b ready_o=%b data_o=%h want all 0", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vo2, r2o, do2} !== 19'd0) begin
            n_bad++;
            $display("FAIL mid_init_cycle: valid_o=%b ready_o=%b data_o=%h want all 0", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 ri2 = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (vo2 !== 2'b11 || r2o !== 1'b1 || do2 !== 16'h3C3C) begin
            n_bad++;
            $display("FAIL mid_reoffer: valid_o=%b ready_o=%b data_o=%h want 11 1 3c3c", vo2, r2o, do2);
        end
        @(posedge clk);
        #1 v2 = 1'b0; ri2 = 2'b00;
    endtask

    task automatic test_back_to_back();
        int sent, hs, cyc, first_acc, first_vld, last_hs;
        sent = 0; hs = 0; cyc = 0; first_acc = -1; first_vld = -1; last_hs = -1;
        m4 = 4'b1111; ri4 = 4'b1111;
        while ((sent < 10 || hs < 40) && cyc < 100) begin
            v4 = (sent < 10);
            d4 = 16'(sent);
            @(negedge clk);
            if (|vo4 && first_vld < 0) first_vld = cyc;
            if (|(vo4 & ri4)) last_hs = cyc;
            hs += $countones(vo4 & ri4);
            if (v4 && r4o) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        v4 = 1'b0;
        n_cmp++;
        if (hs !== 40 || sent !== 10) begin
            n_bad++;
            $display("FAIL b2b_count: sent=%0d handshakes=%0d want 10 40 (budget)", sent, hs);
        end
        n_cmp++;
        if (first_vld - first_acc !== REG) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d want %0d", first_vld - first_acc, REG);
        end
        n_cmp++;
        if (last_hs - first_acc + 1 !== (REG ? 20 : 10)) begin
            n_bad++;
            $display("FAIL b2b_cycles: got %0d want %0d", last_hs - first_acc + 1, REG ? 20 : 10);
        end
    endtask

    task automatic test_random();
        int nxt[4];
        int issued, cyc, drain, idx;
        logic pend;
        issued = 0; cyc = 0; drain = 0; pend = 1'b0;
        for (int k = 0; k < 4; k++) nxt[k] = 0;
        sb.delete();
        while (drain < 6 && cyc < 60000) begin
            @(posedge clk);
            #1 cyc++;
            if (!pend && issued < 10000 && $urandom_range(0, 3) != 0) begin
                v4 = 1'b1;
                d4 = 16'(issued);
                m4 = 4'($urandom);
                sb.push_back('{dat: d4, msk: m4});
                pend = 1'b1;
                issued++;
            end else if (!pend) begin
                v4 = 1'b0;
            end
            ri4 = 4'($urandom | $urandom);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (vo4[k] && ri4[k]) begin
                    idx = nxt[k];
                    while (idx < sb.size() && !sb[idx].msk[k]) idx++;
                    n_cmp++;
                    if (idx >= sb.size() || do4[k*16 +: 16] !== sb[idx].dat) begin
                        n_bad++;
                        $display("FAIL rand_branch%0d: data=%h want %h", k, do4[k*16 +: 16],
                                 (idx < sb.size()) ? sb[idx].dat : 16'hxxxx);
                    end
                    nxt[k] = idx + 1;
                end
            end
            if (v4 && r4o) pend = 1'b0;
            if (issued == 10000 && !pend) drain++;
        end
        v4 = 1'b0;
        n_cmp++;
        if (drain < 6) begin
            n_bad++;
            $display("FAIL rand_budget: issued=%0d after %0d cycles want 10000 retired", issued, cyc);
        end
        for (int k = 0; k < 4; k++) begin
            idx = nxt[k];
            while (idx < sb.size() && !sb[idx].msk[k]) idx++;
            n_cmp++;
            if (idx < sb.size()) begin
                n_bad++;
                $display("FAIL rand_missing%0d: item %0d never delivered want none left", k, idx);
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef SYNC_FORK_OUT_REG_EN
        test_all_ready();
        test_split();
        test_mask4();
        test_reset_mid();
`endif
        do_reset();
        test_back_to_back();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
